// File: rtl/result_ssd_driver_pkg.sv
// Shared definitions for the result seven-segment display driver.
//
// Contents:
//   state_t       - display mode: BLANK, SHOW (steady) and SHOW_OVF (blinking)
//   SEG_OFF       - segment bus value that leaves every segment dark
//   AN_OFF        - anode bus value that leaves every digit dark
//   SEG_PATTERNS  - hex digit to active-low abcdefg pattern table
//   anode_select  - one-cold anode vector for a digit index
package result_ssd_driver_pkg;

    // Display mode. The encodings are fixed so that other project files
    // can decode the state.
    typedef enum logic [1:0] {
        BLANK    = 2'b00,
        SHOW     = 2'b01,
        SHOW_OVF = 2'b10
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Active-low segment patterns, bit 6 = a down to bit 0 = g.
    // A lit segment is a 0.
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    // Pulls exactly one anode low. Index 0 is the rightmost digit.
    function automatic logic [3:0] anode_select(input logic [1:0] k);
        return ~(4'b0001 << k);
    endfunction

endpackage

// File: rtl/result_ssd_driver_seg7_hex_lut.sv
// Combinational hex-to-seven-segment decoder.
//
// Ports:
//   nibble - 4-bit hex digit to decode
//   seg    - active-low segment pattern, seg[6] = a ... seg[0] = g
module seg7_hex_lut
    import result_ssd_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Plain table lookup. The patterns are kept in the package so that
    // every display in the project agrees on glyph shapes.
    always_comb begin
        seg = SEG_PATTERNS[nibble];
    end

endmodule

// File: rtl/result_ssd_driver.sv
// Four-digit multiplexed seven-segment driver for a 16-bit result.
//
// A result is captured on result_valid and shown as four hex digits. The
// digits are scanned from a free-running refresh counter. An overflowed
// result blinks, and clear blanks the display. All outputs are registered
// and all logic runs on the single clock. The counters only act as
// enables.
//
// Ports:
//   clk, rst         - clock (rising edge) and asynchronous active-high reset
//   result           - value to display, nibble [3:0] on the rightmost digit
//   result_valid     - load strobe. Has priority over clear.
//   overflow         - overflow flag captured together with result
//   clear            - synchronous request to blank the display
//   a..g             - active-low segment cathodes
//   an0..an3         - active-low digit anodes, an0 is the rightmost digit
//   showing          - high while the display is in SHOW or SHOW_OVF
module result_ssd_driver
    import result_ssd_driver_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter int BLINK_BITS   = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result,
    input  logic        result_valid,
    input  logic        overflow,
    input  logic        clear,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        an0,
    output logic        an1,
    output logic        an2,
    output logic        an3,
    output logic        showing
);

    state_t                  state;
    state_t                  state_next;
    logic [15:0]             disp_reg;
    logic                    ovf_reg;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [BLINK_BITS-1:0]   blink_cnt;
    logic [1:0]              digit_idx;
    logic [3:0]              nibble;
    logic [6:0]              lut_seg;
    logic                    blink_dark;
    logic [6:0]              seg_next;
    logic [3:0]              an_next;
    logic [6:0]              seg_reg;
    logic [3:0]              an_reg;
    logic                    showing_reg;

    // The top two refresh bits choose the digit. Each digit therefore stays
    // lit for a quarter of the refresh period.
    assign digit_idx = refresh_cnt[REFRESH_BITS-1 -: 2];
    assign nibble    = disp_reg[{digit_idx, 2'b00} +: 4];

    // The dark half of the blink applies only to a captured overflow.
    assign blink_dark = ovf_reg && blink_cnt[BLINK_BITS-1];

    seg7_hex_lut u_lut (
        .nibble (nibble),
        .seg    (lut_seg)
    );

    // Next-state logic and next-output decode. A load wins over clear. The
    // outputs are decoded from the current state and counters, then
    // registered below. Because a single digit index drives the anode
    // vector, at most one anode can be low in any cycle.
    always_comb begin
        state_next = state;
        seg_next   = SEG_OFF;
        an_next    = AN_OFF;

        if (result_valid) begin
            state_next = overflow ? SHOW_OVF : SHOW;
        end else if (clear) begin
            state_next = BLANK;
        end

        case (state)
            SHOW: begin
                seg_next = lut_seg;
                an_next  = anode_select(digit_idx);
            end
            SHOW_OVF: begin
                if (!blink_dark) begin
                    seg_next = lut_seg;
                    an_next  = anode_select(digit_idx);
                end
            end
            default: begin
            end
        endcase
    end

    // State register and captured result. clear changes only the state, so
    // the last result is kept while the display is blank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BLANK;
            disp_reg <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            state <= state_next;
            if (result_valid) begin
                disp_reg <= result;
                ovf_reg  <= overflow;
            end
        end
    end

    // The refresh counter wraps with no gap. The blink counter restarts on
    // every load, so a new overflow result always begins in its lit phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            blink_cnt   <= result_valid ? '0 : blink_cnt + 1'b1;
        end
    end

    // Output registers. Their asynchronous reset blanks the display at the
    // moment rst rises. showing is taken from the next state so that it
    // tracks the state register exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_reg     <= SEG_OFF;
            an_reg      <= AN_OFF;
            showing_reg <= 1'b0;
        end else begin
            seg_reg     <= seg_next;
            an_reg      <= an_next;
            showing_reg <= (state_next != BLANK);
        end
    end

    assign {a, b, c, d, e, f, g} = seg_reg;
    assign an0     = an_reg[0];
    assign an1     = an_reg[1];
    assign an2     = an_reg[2];
    assign an3     = an_reg[3];
    assign showing = showing_reg;

endmodule

// File: tb/tb_result_ssd_driver.sv
// Testbench for result_ssd_driver. It uses small counters so that scanning
// and blinking finish in a few dozen cycles. The digit checks are driven
// from a table. Reset, blinking, clear and mid-scan reset use hand-written
// sequences.
module tb_result_ssd_driver;

    localparam int RB = 4;
    localparam int BB = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] result = 16'h0000;
    logic        result_valid = 1'b0;
    logic        overflow = 1'b0;
    logic        clear = 1'b0;
    logic        a, b, c, d, e, f, g;
    logic        an0, an1, an2, an3;
    logic        showing;
    logic [6:0]  segs;
    logic [3:0]  ans;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string           name;
        logic [15:0]     value;
        logic            ovf;
        logic            clr;
        logic [3:0][6:0] digit_seg;
    } vec_t;

    vec_t vecs[5];

    result_ssd_driver #(
        .REFRESH_BITS (RB),
        .BLINK_BITS   (BB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result       (result),
        .result_valid (result_valid),
        .overflow     (overflow),
        .clear        (clear),
        .a            (a),
        .b            (b),
        .c            (c),
        .d            (d),
        .e            (e),
        .f            (f),
        .g            (g),
        .an0          (an0),
        .an1          (an1),
        .an2          (an2),
        .an3          (an3),
        .showing      (showing)
    );

    assign segs = {a, b, c, d, e, f, g};
    assign ans  = {an3, an2, an1, an0};

    // Free-running clock with a 10 time-unit period.
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge. Inputs are driven
    // and outputs are sampled at this point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Pulse result_valid for one edge, with optional overflow and clear.
    task automatic applyStimulus(input logic [15:0] value, input logic ovf, input logic clr);
        result       = value;
        overflow     = ovf;
        clear        = clr;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        overflow     = 1'b0;
        clear        = 1'b0;
    endtask

    function automatic int countLow(input logic [3:0] an);
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            if (an[i] == 1'b0) n++;
        end
        return n;
    endfunction

    task automatic checkBlank(input string name);
        checkOutput({name, " anodes"}, ans, 4'hF);
        checkOutput({name, " segments"}, segs, 7'h7F);
        checkOutput({name, " showing"}, showing, 1'b0);
    endtask

    // Scan a whole refresh period. In every cycle exactly one anode must be
    // low, and it must show its expected glyph. Each anode must be low for
    // a quarter of the period.
    task automatic scanDigits(input string name, input logic [3:0][6:0] exp_seg, input int cycles);
        int hits[4];
        for (int k = 0; k < 4; k++) hits[k] = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            checkOutput({name, " one anode low"}, countLow(ans), 1);
            for (int k = 0; k < 4; k++) begin
                if (ans[k] == 1'b0) begin
                    hits[k]++;
                    checkOutput($sformatf("%s digit%0d segments", name, k), segs, exp_seg[k]);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s digit%0d lit cycles", name, k), hits[k], cycles / 4);
        end
        checkOutput({name, " showing"}, showing, 1'b1);
    endtask

    initial begin
        vecs[0].name = "1234";      vecs[0].value = 16'h1234; vecs[0].ovf = 1'b0; vecs[0].clr = 1'b0;
        vecs[0].digit_seg[0] = 7'b1001100; vecs[0].digit_seg[1] = 7'b0000110;
        vecs[0].digit_seg[2] = 7'b0010010; vecs[0].digit_seg[3] = 7'b1001111;
        vecs[1].name = "FA80 ovf";  vecs[1].value = 16'hFA80; vecs[1].ovf = 1'b1; vecs[1].clr = 1'b0;
        vecs[1].digit_seg[0] = 7'b0000001; vecs[1].digit_seg[1] = 7'b0000000;
        vecs[1].digit_seg[2] = 7'b0001000; vecs[1].digit_seg[3] = 7'b0111000;
        vecs[2].name = "0008+clr";  vecs[2].value = 16'h0008; vecs[2].ovf = 1'b0; vecs[2].clr = 1'b1;
        vecs[2].digit_seg[0] = 7'b0000000; vecs[2].digit_seg[1] = 7'b0000001;
        vecs[2].digit_seg[2] = 7'b0000001; vecs[2].digit_seg[3] = 7'b0000001;
        vecs[3].name = "5C6E";      vecs[3].value = 16'h5C6E; vecs[3].ovf = 1'b0; vecs[3].clr = 1'b0;
        vecs[3].digit_seg[0] = 7'b0110000; vecs[3].digit_seg[1] = 7'b0100000;
        vecs[3].digit_seg[2] = 7'b0110001; vecs[3].digit_seg[3] = 7'b0100100;
        vecs[4].name = "79BD";      vecs[4].value = 16'h79BD; vecs[4].ovf = 1'b0; vecs[4].clr = 1'b0;
        vecs[4].digit_seg[0] = 7'b1000010; vecs[4].digit_seg[1] = 7'b1100000;
        vecs[4].digit_seg[2] = 7'b0000100; vecs[4].digit_seg[3] = 7'b0001111;

        // Reset, then stay idle: the display must remain blank.
        tick();
        tick();
        checkBlank("in reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkBlank("idle");
        end

        // Table-driven loads. Outputs pick up the new value one edge after
        // the load edge, so the scan begins with the next tick.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].value, vecs[v].ovf, vecs[v].clr);
            scanDigits(vecs[v].name, vecs[v].digit_seg, 16);
        end

        // Overflow blink: 32 cycles lit, 32 dark, repeating.
        applyStimulus(16'hFA80, 1'b1, 1'b0);
        for (int i = 1; i <= 128; i++) begin
            tick();
            if ((((i - 1) / 32) % 2) == 0) begin
                checkOutput("blink lit one anode low", countLow(ans), 1);
                if (ans[3] == 1'b0) checkOutput("blink lit digit3 F", segs, 7'b0111000);
            end else begin
                checkOutput("blink dark anodes", ans, 4'hF);
            end
        end
        checkOutput("blink showing", showing, 1'b1);

        // Clear while in SHOW_OVF, then a steady result that must not blink.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clear showing", showing, 1'b0);
        tick();
        checkBlank("after clear");
        tick();
        checkBlank("after clear idle");
        applyStimulus(16'h1234, 1'b0, 1'b0);
        for (int i = 0; i < 80; i++) begin
            tick();
            checkOutput("steady after ovf one anode low", countLow(ans), 1);
        end
        checkOutput("steady showing", showing, 1'b1);

        // Reset mid-scan blanks at once. A load seen at an edge during reset
        // is ignored, and loads after release are accepted.
        #2;
        rst = 1'b1;
        #1;
        checkBlank("async reset");
        result       = 16'h5555;
        result_valid = 1'b1;
        tick();
        checkBlank("reset edge");
        rst          = 1'b0;
        result_valid = 1'b0;
        tick();
        tick();
        checkBlank("after reset release");
        applyStimulus(16'h0001, 1'b0, 1'b0);
        begin
            logic [3:0][6:0] exp_one;
            exp_one[0] = 7'b1001111;
            exp_one[1] = 7'b0000001;
            exp_one[2] = 7'b0000001;
            exp_one[3] = 7'b0000001;
            scanDigits("0001 post-reset", exp_one, 16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/result_ssd_driver.md
RESULT_SSD_DRIVER -- requirements
Module: result_ssd_driver

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 18, meaning refresh counter width; each digit is lit for 2^(REFRESH_BITS-2) cycles.
REQ-002 SHALL have parameter BLINK_BITS, default 26, meaning blink counter width; overflow blink half-period is 2^(BLINK_BITS-1) cycles.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port result, input, 16, the value to display as four hex digits.
REQ-006 SHALL have port result_valid, input, 1, a load strobe sampled each cycle.
REQ-007 SHALL have port overflow, input, 1, the overflow flag captured with result.
REQ-008 SHALL have port clear, input, 1, the synchronous display-blank request.
REQ-009 SHALL have ports a, b, c, d, e, f, g, output, 1 each, the active-low segment cathodes.
REQ-010 SHALL have ports an0, an1, an2, an3, output, 1 each, the active-low digit anodes; an0 is the rightmost digit, showing nibble [3:0].
REQ-011 SHALL have port showing, output, 1, high while state is SHOW or SHOW_OVF.

Function
REQ-012 SHALL implement states BLANK, SHOW and SHOW_OVF.
REQ-013 SHALL, on result_valid=1, latch result into disp_reg and overflow into ovf_reg, then enter SHOW if overflow=0 or SHOW_OVF if overflow=1, from any state.
REQ-014 SHALL, on clear=1 with result_valid=0, enter BLANK and leave disp_reg unchanged.
REQ-015 SHALL give result_valid priority when clear and result_valid are both high in the same cycle.
REQ-016 SHALL free-run the refresh counter, wrapping from all-ones to 0 with no gap; digit index k = refresh counter bits [REFRESH_BITS-1:REFRESH_BITS-2].
REQ-017 SHALL, in SHOW, drive exactly one anode low (an_k), with segments set to the hex decode of disp_reg[4k+3:4k].
REQ-018 SHALL, in SHOW_OVF, behave as in SHOW while blink counter MSB=0, and drive all anodes high while MSB=1.
REQ-019 SHALL clear the blink counter to 0 on every result_valid, so each new overflow result starts in its visible phase.
REQ-020 SHALL, in BLANK, drive all anodes high and all segments high.
REQ-021 SHALL register all outputs; a result_valid sampled at edge N SHALL appear on the selected digit from edge N+1.
REQ-022 SHALL use the hex decode, a..g active-low: 0=0000001, 1=1001111, 4=1001100, 8=0000000, A=0001000, F=0111000, with the remaining digits in standard form.
REQ-023 SHALL never drive more than one anode low in any cycle, including the cycle of a state change.

Reset
REQ-024 SHALL, while rst=1, set state=BLANK, disp_reg=0, ovf_reg=0, both counters=0, a..g=1, an0..an3=1 and showing=0.
REQ-025 SHALL, when rst is asserted mid-display, blank the outputs immediately (asynchronously), with no partial digit held.
REQ-026 SHALL ignore result_valid in the first edge after rst deasserts only if that edge occurs while rst=1; otherwise it is accepted normally.

Structure
REQ-027 SHALL take the state encodings (BLANK=2'b00, SHOW=2'b01, SHOW_OVF=2'b10) and the 16-entry segment pattern constants from the shared project package/include.
REQ-028 SHALL instantiate one combinational sub-module, seg7_hex_lut (4-bit nibble in, 7-bit abcdefg out), fed by the multiplexed nibble.
REQ-029 SHALL NOT use clock dividers or derived clocks; counters are used as enables only.

Verification (REFRESH_BITS=4, BLINK_BITS=6)
REQ-030 SHALL cover: reset, then 20 idle cycles -> an0..an3=1111, a..g=1111111, showing=0.
REQ-031 SHALL cover: result=16'h1234 with result_valid pulse -> over 16 cycles each anode is low for 4 cycles; an0 low gives 1001100, an3 low gives 1001111.
REQ-032 SHALL cover: result=16'hFA80 with overflow=1 -> digits visible for 32 cycles, all anodes high for 32 cycles, repeating; an3 low gives 0111000.
REQ-033 SHALL cover: clear and result_valid (16'h0008) in the same cycle -> state SHOW; an0 low gives 0000000.
REQ-034 SHALL cover: clear while in SHOW_OVF -> BLANK on the next edge; a later result_valid with overflow=0 shows the new value steadily, with no blinking.
REQ-035 SHALL cover: rst asserted mid-scan -> outputs all 1 within the same cycle; every cycle checked for at most one anode low.
